// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: CP0 register indices, exception codes and
// the SR/Cause field positions used by the exception unit.
package cpu_defs_pkg;

    typedef logic [4:0] cp0_idx_t;
    typedef logic [4:0] exc_code_t;

    localparam cp0_idx_t CP0_SR    = 5'd12;
    localparam cp0_idx_t CP0_CAUSE = 5'd13;
    localparam cp0_idx_t CP0_EPC   = 5'd14;
    localparam cp0_idx_t CP0_PRID  = 5'd15;

    localparam exc_code_t EXC_INT  = 5'd0;
    localparam exc_code_t EXC_ADEL = 5'd4;
    localparam exc_code_t EXC_ADES = 5'd5;
    localparam exc_code_t EXC_RI   = 5'd10;
    localparam exc_code_t EXC_OV   = 5'd12;

    localparam int SR_IE_BIT    = 0;
    localparam int SR_EXL_BIT   = 1;
    localparam int SR_IM_LO     = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_BD_BIT = 31;
    localparam int INT_LINES    = 6;

    localparam logic [31:0] PRID_DEFAULT       = 32'h4D49_5053;
    localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

endpackage

// File: rtl/cp0_exc_unit_if.sv
// M-stage side of the CP0 exception unit: exception inputs, mtc0/mfc0
// access, eret, and the flush/redirect outputs back to the pipeline.
interface cp0_exc_unit_if;
    import cpu_defs_pkg::*;

    logic [31:0]          pc_in;
    logic                 bd_in;
    exc_code_t            exc_code_in;
    logic [INT_LINES-1:0] hw_int;
    cp0_idx_t             cp0_addr;
    logic [31:0]          cp0_wdata;
    logic                 cp0_we;
    logic                 eret_in;
    logic [31:0]          cp0_rdata;
    logic [31:0]          epc_out;
    logic                 req;
    logic [31:0]          handler_pc;

    modport master (
        output pc_in, bd_in, exc_code_in, hw_int, cp0_addr, cp0_wdata,
               cp0_we, eret_in,
        input  cp0_rdata, epc_out, req, handler_pc
    );

    modport slave (
        input  pc_in, bd_in, exc_code_in, hw_int, cp0_addr, cp0_wdata,
               cp0_we, eret_in,
        output cp0_rdata, epc_out, req, handler_pc
    );

endinterface

// File: rtl/cp0_req_arbiter.sv
// Combinational interrupt/exception arbitration: decides whether the M
// instruction is taken and which ExcCode gets recorded in Cause.
module cp0_req_arbiter
    import cpu_defs_pkg::*;
(
    input  logic [INT_LINES-1:0] hw_int,
    input  logic [INT_LINES-1:0] im,
    input  logic                 ie,
    input  logic                 exl,
    input  exc_code_t            exc_code,
    output logic                 req,
    output exc_code_t            rec_code
);

    logic int_req;
    logic exc_req;

    // EXL masks everything: nested exceptions are not supported.
    assign int_req  = (|(hw_int & im)) & ie & ~exl;
    assign exc_req  = (exc_code != EXC_INT) & ~exl;
    assign req      = int_req | exc_req;
    assign rec_code = int_req ? EXC_INT : exc_code;

endmodule

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception/interrupt receiver at the M stage: holds SR,
// Cause and EPC, raises the flush request and services mtc0/mfc0/eret.
module cp0_exc_unit
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] PRID       = PRID_DEFAULT,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    cp0_exc_unit_if.slave bus
);

    logic [INT_LINES-1:0] sr_im;
    logic                 sr_exl;
    logic                 sr_ie;
    logic                 cause_bd;
    logic [INT_LINES-1:0] cause_ip;
    exc_code_t            cause_exc;
    logic [31:0]          epc_q;

    logic                 req;
    exc_code_t            rec_code;
    logic [31:0]          epc_next;
    logic [31:0]          sr_word;
    logic [31:0]          cause_word;

    cp0_req_arbiter u_arb (
        .hw_int   (bus.hw_int),
        .im       (sr_im),
        .ie       (sr_ie),
        .exl      (sr_exl),
        .exc_code (bus.exc_code_in),
        .req      (req),
        .rec_code (rec_code)
    );

    // A delay-slot instruction restarts at its branch.
    assign epc_next = (bus.bd_in ? bus.pc_in - 32'd4 : bus.pc_in) & ~32'd3;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc_q     <= '0;
        end else begin
            cause_ip <= bus.hw_int;
            if (req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bus.bd_in;
                cause_exc <= rec_code;
                epc_q     <= epc_next;
            end else begin
                if (bus.cp0_we) begin
                    case (bus.cp0_addr)
                        CP0_SR: begin
                            sr_im  <= bus.cp0_wdata[SR_IM_LO +: INT_LINES];
                            sr_exl <= bus.cp0_wdata[SR_EXL_BIT];
                            sr_ie  <= bus.cp0_wdata[SR_IE_BIT];
                        end
                        CP0_EPC: epc_q <= bus.cp0_wdata & ~32'd3;
                        default: ;
                    endcase
                end
                // Later assignment wins: eret clears EXL after an mtc0 SR.
                if (bus.eret_in) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        sr_word                              = '0;
        sr_word[SR_IM_LO +: INT_LINES]       = sr_im;
        sr_word[SR_EXL_BIT]                  = sr_exl;
        sr_word[SR_IE_BIT]                   = sr_ie;
        cause_word                           = '0;
        cause_word[CAUSE_BD_BIT]             = cause_bd;
        cause_word[CAUSE_IP_LO +: INT_LINES] = cause_ip;
        cause_word[CAUSE_EXC_LO +: 5]        = cause_exc;
    end

    always_comb begin
        bus.cp0_rdata = 32'h0;
        case (bus.cp0_addr)
            CP0_SR:    bus.cp0_rdata = sr_word;
            CP0_CAUSE: bus.cp0_rdata = cause_word;
            CP0_EPC:   bus.cp0_rdata = epc_q;
            CP0_PRID:  bus.cp0_rdata = PRID;
            default:   bus.cp0_rdata = 32'h0;
        endcase
    end

    assign bus.req        = req;
    assign bus.epc_out    = epc_q;
    assign bus.handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Scoreboard bench for cp0_exc_unit: directed cycles push expected req,
// cp0_rdata and epc_out; a negedge monitor pops and compares.
module tb_cp0_exc_unit;

    typedef struct {
        string       name;
        logic        req;
        logic [31:0] rdata;
        logic [31:0] epc;
    } exp_t;

    logic   clk;
    logic   reset;
    exp_t   sb[$];
    int     n_cmp;
    int     n_bad;
    bit     drv_done;

    cp0_exc_unit_if bus();

    cp0_exc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %08h want %08h", nm, got, want);
        end
    endtask

    // One cycle of stimulus: inputs are applied just after the edge, the
    // expected combinational outputs for that cycle go into the scoreboard.
    task automatic cyc(input string nm, input logic rst_n, input logic [31:0] pc,
                       input logic bd, input logic [4:0] exc, input logic [5:0] hw,
                       input logic [4:0] addr, input logic [31:0] wd, input logic we,
                       input logic er, input logic x_req, input logic [31:0] x_rd,
                       input logic [31:0] x_epc);
        exp_t e;
        @(posedge clk);
        #1;
        reset           = rst_n;
        bus.pc_in       = pc;
        bus.bd_in       = bd;
        bus.exc_code_in = exc;
        bus.hw_int      = hw;
        bus.cp0_addr    = addr;
        bus.cp0_wdata   = wd;
        bus.cp0_we      = we;
        bus.eret_in     = er;
        e.name  = nm;
        e.req   = x_req;
        e.rdata = x_rd;
        e.epc   = x_epc;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check32({e.name, "/req"}, {31'd0, bus.req}, {31'd0, e.req});
            check32({e.name, "/rdata"}, bus.cp0_rdata, e.rdata);
            check32({e.name, "/epc"}, bus.epc_out, e.epc);
            check32({e.name, "/hpc"}, bus.handler_pc, 32'h0000_4180);
        end
    end

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        drv_done = 1'b0;
        reset           = 1'b0;
        bus.pc_in       = '0;
        bus.bd_in       = 1'b0;
        bus.exc_code_in = '0;
        bus.hw_int      = '0;
        bus.cp0_addr    = '0;
        bus.cp0_wdata   = '0;
        bus.cp0_we      = 1'b0;
        bus.eret_in     = 1'b0;

        //    name           rst pc            bd exc    hw     addr   wdata         we er  req  rdata         epc
        cyc("rst_hold",      0, 32'h0,        0, 5'd0,  6'd0,  5'd12, 32'h0,        0, 0,  0, 32'h0,        32'h0);
        cyc("rst_cause",     1, 32'h0,        0, 5'd0,  6'd0,  5'd13, 32'h0,        0, 0,  0, 32'h0,        32'h0);
        cyc("ov_take",       1, 32'h3004,     0, 5'd12, 6'd0,  5'd12, 32'h0,        0, 0,  1, 32'h0,        32'h0);
        cyc("ov_epc",        1, 32'h0,        0, 5'd0,  6'd0,  5'd14, 32'h0,        0, 0,  0, 32'h3004,     32'h3004);
        cyc("ov_cause",      1, 32'h0,        0, 5'd0,  6'd0,  5'd13, 32'h0,        0, 0,  0, 32'h30,       32'h3004);
        cyc("ov_sr",         1, 32'h0,        0, 5'd0,  6'd0,  5'd12, 32'h0,        0, 0,  0, 32'h2,        32'h3004);
        cyc("exl_mask",      1, 32'h5000,     0, 5'd12, 6'd0,  5'd14, 32'h0,        0, 0,  0, 32'h3004,     32'h3004);
        cyc("eret",          1, 32'h0,        0, 5'd0,  6'd0,  5'd14, 32'h0,        0, 1,  0, 32'h3004,     32'h3004);
        cyc("eret_sr",       1, 32'h0,        0, 5'd0,  6'd0,  5'd12, 32'h0,        0, 0,  0, 32'h0,        32'h3004);
        cyc("bd_take",       1, 32'h3010,     1, 5'd12, 6'd0,  5'd12, 32'h0,        0, 0,  1, 32'h0,        32'h3004);
        cyc("bd_cause",      1, 32'h0,        0, 5'd0,  6'd0,  5'd13, 32'h0,        0, 0,  0, 32'h8000_0030, 32'h300C);
        cyc("bd_epc",        1, 32'h0,        0, 5'd0,  6'd0,  5'd14, 32'h0,        0, 0,  0, 32'h300C,     32'h300C);
        cyc("prid",          1, 32'h0,        0, 5'd0,  6'd0,  5'd15, 32'h0,        0, 0,  0, 32'h4D49_5053, 32'h300C);
        cyc("reg7_wr",       1, 32'h0,        0, 5'd0,  6'd0,  5'd7,  32'hFFFF_FFFF, 1, 0,  0, 32'h0,        32'h300C);
        cyc("cause_wr",      1, 32'h0,        0, 5'd0,  6'd0,  5'd13, 32'hFFFF_FFFF, 1, 0,  0, 32'h8000_0030, 32'h300C);
        cyc("cause_keep",    1, 32'h0,        0, 5'd0,  6'd0,  5'd13, 32'h0,        0, 0,  0, 32'h8000_0030, 32'h300C);
        cyc("epc_wr",        1, 32'h0,        0, 5'd0,  6'd0,  5'd14, 32'h3007,     1, 0,  0, 32'h300C,     32'h300C);
        cyc("epc_align",     1, 32'h0,        0, 5'd0,  6'd0,  5'd14, 32'h0,        0, 0,  0, 32'h3004,     32'h3004);
        cyc("sr_wr_eret",    1, 32'h0,        0, 5'd0,  6'd0,  5'd12, 32'h403,      1, 1,  0, 32'h2,        32'h3004);
        cyc("sr_after",      1, 32'h0,        0, 5'd0,  6'd0,  5'd12, 32'h0,        0, 0,  0, 32'h401,      32'h3004);
        cyc("int_take",      1, 32'h3020,     0, 5'd12, 6'd1,  5'd13, 32'h0,        0, 0,  1, 32'h8000_0030, 32'h3004);
        cyc("int_cause",     1, 32'h0,        0, 5'd0,  6'd1,  5'd13, 32'h0,        0, 0,  0, 32'h400,      32'h3020);
        cyc("int_sr",        1, 32'h0,        0, 5'd0,  6'd0,  5'd12, 32'h0,        0, 0,  0, 32'h403,      32'h3020);
        cyc("eret2",         1, 32'h0,        0, 5'd0,  6'd0,  5'd13, 32'h0,        0, 1,  0, 32'h0,        32'h3020);
        cyc("req_mtc0",      1, 32'h3030,     0, 5'd12, 6'd0,  5'd14, 32'h1234_5678, 1, 0,  1, 32'h3020,     32'h3020);
        cyc("mtc0_drop",     1, 32'h0,        0, 5'd0,  6'd0,  5'd14, 32'h0,        0, 0,  0, 32'h3030,     32'h3030);
        cyc("eret3",         1, 32'h0,        0, 5'd0,  6'd0,  5'd12, 32'h0,        0, 1,  0, 32'h403,      32'h3030);
        cyc("rst_vs_req",    0, 32'h3040,     0, 5'd12, 6'd0,  5'd12, 32'h0,        0, 0,  1, 32'h401,      32'h3030);
        cyc("rst_sr",        1, 32'h0,        0, 5'd0,  6'd0,  5'd12, 32'h0,        0, 0,  0, 32'h0,        32'h0);
        cyc("rst_cause2",    1, 32'h0,        0, 5'd0,  6'd0,  5'd13, 32'h0,        0, 0,  0, 32'h0,        32'h0);
        cyc("post_rst_ov",   1, 32'h3050,     0, 5'd12, 6'd0,  5'd15, 32'h0,        0, 0,  1, 32'h4D49_5053, 32'h0);
        cyc("post_rst_epc",  1, 32'h0,        0, 5'd0,  6'd0,  5'd14, 32'h0,        0, 0,  0, 32'h3050,     32'h3050);

        drv_done = 1'b1;
        repeat (3) @(posedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain left %0d want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Coprocessor-0 exception/interrupt receiver for the 5-stage MIPS pipeline; sits at the M stage.
- Consumes the exception codes the datapath raises, including the E-stage ALU arithmetic overflow (ExcCode 12, Ov), plus the 6 external hardware interrupt lines.
- Decides whether to take an exception or interrupt, records SR/Cause/EPC, and asserts the flush/redirect request.
- Services mtc0/mfc0 register access and eret return.

Parameters:
- PRID, 32'h4D495053, read-only value returned for CP0 register 15.
- HANDLER_PC, 32'h0000_4180, exception vector; exported for the PC mux.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset; sampled on rising clk; 0 = reset.
- pc_in  input  32  PC of the instruction currently in M.
- bd_in  input  1  M instruction sits in a branch delay slot.
- exc_code_in  input  5  pending exception code; 0 = none; 12 = overflow from ALU.
- hw_int  input  6  external interrupt lines, level-sensitive.
- cp0_addr  input  5  register index for mtc0/mfc0.
- cp0_wdata  input  32  mtc0 write data.
- cp0_we  input  1  mtc0 write enable.
- eret_in  input  1  eret in M.
- cp0_rdata  output  32  mfc0 read data, combinational.
- epc_out  output  32  current EPC register, for the eret redirect.
- req  output  1  take exception/interrupt this cycle; flushes the pipeline.
- handler_pc  output  32  constant HANDLER_PC.

Behaviour:
- Registers: SR(12) holds IM[15:10], EXL[1], IE[0]; other bits read 0.
- Cause(13) holds BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
- EPC(14) is 32-bit, always word-aligned.
- PRId(15) is constant PRID.
- Any other index reads 32'h0; writes to it are ignored.
- Reset (reset==0 at clk edge): SR=0, Cause=0, EPC=0. Next cycle req=0 and cp0_rdata reflects zeroed registers.
- Reset overrides every simultaneous event, including req, eret and mtc0.
- int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
- exc_req = (exc_code_in != 0) & ~SR.EXL.
- req = int_req | exc_req; combinational, same cycle as the M instruction.
- Interrupt has priority over exception. Recorded ExcCode = int_req ? 0 : exc_code_in.
- On req, at the next edge:
  - EXL<=1.
  - Cause.BD<=bd_in.
  - Cause.ExcCode<=recorded code.
  - EPC<= (bd_in ? pc_in-4 : pc_in) with bits[1:0] forced to 0.
  - An mtc0 in the same cycle is dropped; the instruction is flushed.
- Cause.IP<=hw_int every cycle, regardless of req/EXL.
- eret_in with req=0: EXL<=0 at the next edge. eret never raises req itself.
- mtc0 (cp0_we & ~req) writes only the implemented fields.
  - Writing Cause changes nothing; IP/BD/ExcCode are hardware-owned.
  - Writing EPC stores wdata with bits[1:0] cleared.
- Simultaneous mtc0 SR and eret: the mtc0 value is written first, then EXL is cleared.
- Read-after-write: cp0_rdata shows the old value in the write cycle and the new value from the next cycle. The pipeline stalls/forwards externally.
- EXL=1 masks both exceptions and interrupts. Nested exceptions are not supported.
- epc_out is the EPC register value, with no bypass.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - CP0 register index constants: SR=12, CAUSE=13, EPC=14, PRID=15.
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12.
  - SR/Cause bit-position constants.
  - HANDLER_PC default.
- One natural sub-module, cp0_req_arbiter: combinational int/exc priority producing req and the recorded ExcCode. Register state stays in the top.

Test Plan:
- Overflow: SR=0, exc_code_in=12, pc_in=0x0000_3004, bd_in=0 -> req=1 same cycle. Next cycle EPC=0x3004, Cause.ExcCode=12, Cause.BD=0, SR.EXL=1.
- Delay slot: exc_code_in=12, pc_in=0x3010, bd_in=1 -> EPC=0x300C, Cause[31]=1.
- Interrupt priority: mtc0 SR=0x0000_0401 (IM0=1, IE=1), hw_int=6'b000001, exc_code_in=12 -> req=1, ExcCode=0, Cause.IP=6'b000001.
- Masking and return: with EXL=1, exc_code_in=12 -> req=0 and EPC unchanged. Then eret_in=1 -> EXL=0, and the next exc_code_in=12 -> req=1.
- Register access:
  - mfc0 15 -> PRID.
  - mfc0 7 -> 0.
  - mtc0 EPC=0x3007 -> read 0x3004.
  - mtc0 Cause=0xFFFF_FFFF -> Cause unchanged.
  - mtc0 in a req cycle -> dropped.
- Reset mid-operation: reset=0 in the same cycle as req=1 (exc 12) -> after the edge SR=Cause=EPC=0 and req=0.
